// File: rtl/histogram_builder_pkg.sv
// Shared definitions for the histogram builder: FSM state encoding,
// default geometry and the bin indices that are tapped for the classifier.
// Imported by histogram_builder and hist_bin_array.
package histogram_builder_pkg;

    // Default geometry
    localparam int DEF_PIX_W    = 8;
    localparam int DEF_NUM_BINS = 64;
    localparam int DEF_BIN_W    = 12;

    // Frame pixel counter width
    localparam int PIX_COUNT_W  = 20;

    // Bins presented to the classifier
    localparam int NUM_TAPS     = 4;
    localparam int TAP_BIN_0    = 0;
    localparam int TAP_BIN_34   = 34;
    localparam int TAP_BIN_38   = 38;
    localparam int TAP_BIN_39   = 39;

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_ACCUM     = 2'd1,
        ST_HANDOFF   = 2'd2,
        ST_WAIT_DONE = 2'd3
    } hb_state_t;

    // Increment that sticks at all-ones
    function automatic logic [PIX_COUNT_W-1:0] sat_inc_count(input logic [PIX_COUNT_W-1:0] v);
        return (&v) ? v : v + PIX_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/hist_bin_array.sv
// Histogram bin storage with synchronous clear and saturating increment.
// Ports: clk/rst, clear_i (zero all bins), inc_i + idx_i (bump one bin),
//        taps_o (registered counts of the four classifier bins, no extra latency).
module hist_bin_array
    import histogram_builder_pkg::*;
#(
    parameter int NUM_BINS = DEF_NUM_BINS,
    parameter int BIN_W    = DEF_BIN_W,
    parameter int IDX_W    = $clog2(NUM_BINS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear_i,
    input  logic                               inc_i,
    input  logic [IDX_W-1:0]                   idx_i,
    output logic [NUM_TAPS-1:0][BIN_W-1:0]     taps_o
);

    logic [BIN_W-1:0] bins_q [NUM_BINS];
    logic [BIN_W-1:0] sel_bin;
    logic [BIN_W-1:0] sel_bin_d;

    // Only the addressed bin can change on an increment, so a single
    // next-value path is shared across the array.
    always_comb begin
        sel_bin   = bins_q[idx_i];
        sel_bin_d = (&sel_bin) ? sel_bin : sel_bin + BIN_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                bins_q[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                bins_q[i] <= '0;
            end
        end else if (inc_i) begin
            bins_q[idx_i] <= sel_bin_d;
        end
    end

    assign taps_o[0] = bins_q[TAP_BIN_0];
    assign taps_o[1] = bins_q[TAP_BIN_34];
    assign taps_o[2] = bins_q[TAP_BIN_38];
    assign taps_o[3] = bins_q[TAP_BIN_39];

endmodule

// File: rtl/histogram_builder.sv
// Builds a per-frame intensity histogram, hands four bins to an external
// classifier and latches its result.
// Ports: pixel_valid/pixel_ready/pixel_data/pixel_last (pixel stream in),
//        start_classification + bin_* (classifier request), classification_done
//        + classification (classifier reply), result/result_valid, pixel_count.
module histogram_builder
    import histogram_builder_pkg::*;
#(
    parameter int PIX_W    = DEF_PIX_W,
    parameter int NUM_BINS = DEF_NUM_BINS,
    parameter int BIN_W    = DEF_BIN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pixel_valid,
    input  logic [PIX_W-1:0]       pixel_data,
    input  logic                   pixel_last,
    output logic                   pixel_ready,
    output logic                   start_classification,
    output logic [BIN_W-1:0]       bin_0,
    output logic [BIN_W-1:0]       bin_34,
    output logic [BIN_W-1:0]       bin_38,
    output logic [BIN_W-1:0]       bin_39,
    input  logic                   classification_done,
    input  logic [1:0]             classification,
    output logic [1:0]             result,
    output logic                   result_valid,
    output logic [PIX_COUNT_W-1:0] pixel_count
);

    localparam int IDX_W = $clog2(NUM_BINS);

    hb_state_t               state_q, state_d;
    logic                    done_q;
    logic [1:0]              result_q;
    logic                    result_valid_q;
    logic [PIX_COUNT_W-1:0]  count_q, count_d;

    logic                    clear_bins;
    logic                    accept;
    logic                    complete;
    logic [IDX_W-1:0]        bin_idx;
    logic [NUM_TAPS-1:0][BIN_W-1:0] taps;

    // Intensity is binned by its top bits; the low bits are discarded.
    assign bin_idx = pixel_data[PIX_W-1 -: IDX_W];

    generate
        if (PIX_W > IDX_W) begin : g_unused_lsbs
            logic unused_pix_lsbs;
            assign unused_pix_lsbs = ^pixel_data[PIX_W-IDX_W-1:0];
        end
    endgenerate

    assign accept = pixel_valid && pixel_ready;

    always_comb begin
        state_d              = state_q;
        pixel_ready          = 1'b0;
        start_classification = 1'b0;
        clear_bins           = 1'b0;
        complete             = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_bins = 1'b1;
                state_d    = ST_ACCUM;
            end
            ST_ACCUM: begin
                pixel_ready = 1'b1;
                if (pixel_valid && pixel_last) begin
                    state_d = ST_HANDOFF;
                end
            end
            ST_HANDOFF: begin
                start_classification = 1'b1;
                state_d              = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Edge, not level: a done left high by the previous frame
                // must not complete this one.
                if (classification_done && !done_q) begin
                    complete = 1'b1;
                    state_d  = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (clear_bins) begin
            count_d = '0;
        end else if (accept) begin
            count_d = sat_inc_count(count_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_CLEAR;
            done_q         <= 1'b0;
            result_q       <= 2'b00;
            result_valid_q <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            done_q         <= classification_done;
            result_valid_q <= complete;
            count_q        <= count_d;
            if (complete) begin
                result_q <= classification;
            end
        end
    end

    hist_bin_array #(
        .NUM_BINS (NUM_BINS),
        .BIN_W    (BIN_W),
        .IDX_W    (IDX_W)
    ) u_bins (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_bins),
        .inc_i   (accept),
        .idx_i   (bin_idx),
        .taps_o  (taps)
    );

    assign bin_0        = taps[0];
    assign bin_34       = taps[1];
    assign bin_38       = taps[2];
    assign bin_39       = taps[3];
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign pixel_count  = count_q;

endmodule

// File: tb/tb_histogram_builder.sv
module tb_histogram_builder;

    logic        clk = 1'b0;
    logic        rst;
    logic        pixel_valid;
    logic [7:0]  pixel_data;
    logic        pixel_last;
    logic        pixel_ready;
    logic        start_classification;
    logic [11:0] bin_0, bin_34, bin_38, bin_39;
    logic        classification_done;
    logic [1:0]  classification;
    logic [1:0]  result;
    logic        result_valid;
    logic [19:0] pixel_count;

    int errors = 0;
    int checks = 0;

    // Scoreboard: expected classifier results, pushed when the reply is driven
    logic [1:0] res_q[$];
    // Reference histogram model
    int model_bins [64];
    int model_count;

    histogram_builder dut (
        .clk                  (clk),
        .rst                  (rst),
        .pixel_valid          (pixel_valid),
        .pixel_data           (pixel_data),
        .pixel_last           (pixel_last),
        .pixel_ready          (pixel_ready),
        .start_classification (start_classification),
        .bin_0                (bin_0),
        .bin_34               (bin_34),
        .bin_38               (bin_38),
        .bin_39               (bin_39),
        .classification_done  (classification_done),
        .classification       (classification),
        .result               (result),
        .result_valid         (result_valid),
        .pixel_count          (pixel_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_bins[i] = 0;
        model_count = 0;
    endtask

    task automatic model_add(input logic [7:0] d);
        int idx;
        idx = int'(d) / 4;
        if (model_bins[idx] < 4095) model_bins[idx]++;
        if (model_count < 1048575) model_count++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".bin_0"},  32'(bin_0),  model_bins[0]);
        check({tag, ".bin_34"}, 32'(bin_34), model_bins[34]);
        check({tag, ".bin_38"}, 32'(bin_38), model_bins[38]);
        check({tag, ".bin_39"}, 32'(bin_39), model_bins[39]);
        check({tag, ".count"},  32'(pixel_count), model_count);
    endtask

    // Called at a falling edge; waits (bounded) until the block is accepting
    task automatic wait_ready(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (pixel_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".wait_ready"}, 32'(ok), 32'd1);
    endtask

    // Drives n back-to-back pixels; returns at the falling edge after the last accept
    task automatic send(input logic [7:0] d, input int n, input bit last_at_end);
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = d;
            pixel_last  = last_at_end && (i == n - 1);
            model_add(d);
            @(negedge clk);
        end
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
    endtask

    // Classifier reply: drop done, then raise it with the class; expects one result pulse
    task automatic finish_frame(input logic [1:0] cls, input string tag);
        bit         found = 1'b0;
        logic [1:0] exp;
        classification_done = 1'b0;
        @(negedge clk);
        classification      = cls;
        classification_done = 1'b1;
        res_q.push_back(cls);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (result_valid) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, ".result_valid_seen"}, 32'(found), 32'd1);
        exp = res_q.pop_front();
        check({tag, ".result"}, 32'(result), 32'(exp));
        classification = ~cls;
        @(negedge clk);
        check({tag, ".result_valid_pulse"}, 32'(result_valid), 32'd0);
        check({tag, ".result_held"}, 32'(result), 32'(exp));
        check({tag, ".ready_after_clear"}, 32'(pixel_ready), 32'd1);
        model_clear();
        check_all({tag, ".cleared"});
    endtask

    initial begin
        rst                 = 1'b1;
        pixel_valid         = 1'b0;
        pixel_data          = 8'h00;
        pixel_last          = 1'b0;
        classification_done = 1'b0;
        classification      = 2'b00;
        model_clear();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst.ready",  32'(pixel_ready), 32'd0);
        check("rst.start",  32'(start_classification), 32'd0);
        check("rst.rvalid", 32'(result_valid), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check_all("rst");
        rst = 1'b0;
        #1;
        check("rst.ready_in_clear", 32'(pixel_ready), 32'd0);
        @(negedge clk);
        check("rst.ready_rise", 32'(pixel_ready), 32'd1);

        // 100 pixels at 0x00 ending with last
        send(8'h00, 100, 1'b1);
        check("t1.start", 32'(start_classification), 32'd1);
        check("t1.ready_handoff", 32'(pixel_ready), 32'd0);
        check_all("t1");
        @(negedge clk);
        check("t1.start_one_cycle", 32'(start_classification), 32'd0);
        check("t1.ready_wait", 32'(pixel_ready), 32'd0);
        finish_frame(2'b10, "t1");

        // Mixed bins; done still high from previous frame (stale level)
        send(8'h88, 20, 1'b0);
        send(8'h98, 5, 1'b0);
        send(8'h9C, 3, 1'b1);
        check("t2.start", 32'(start_classification), 32'd1);
        check_all("t2");
        classification = 2'b01;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t2.stale_no_result", 32'(result_valid), 32'd0);
            check("t2.stale_ready", 32'(pixel_ready), 32'd0);
        end
        check_all("t2.frozen");
        finish_frame(2'b01, "t2");

        // Saturation of bin_0 with pixel_count past 4095
        send(8'h00, 5000, 1'b1);
        check("t3.bin_0_sat", 32'(bin_0), 32'd4095);
        check("t3.count", 32'(pixel_count), 32'd5000);
        check_all("t3");
        finish_frame(2'b11, "t3");

        // Reset mid-frame discards it
        send(8'h00, 50, 1'b0);
        rst = 1'b1;
        #1;
        model_clear();
        check_all("t4.midrst");
        check("t4.midrst.ready", 32'(pixel_ready), 32'd0);
        check("t4.midrst.result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_ready("t4");
        send(8'h9C, 10, 1'b1);
        check("t4.bin_39", 32'(bin_39), 32'd10);
        check_all("t4");
        @(negedge clk);
        // Reset while waiting for the classifier, then a done edge arrives
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        classification_done = 1'b0;
        @(negedge clk);
        classification      = 2'b11;
        classification_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4.no_result_after_rst", 32'(result_valid), 32'd0);
        end
        check("t4.result_zero", 32'(result), 32'd0);
        model_clear();
        check_all("t4.after_rst");

        // pixel_valid toggling every cycle
        wait_ready("t5");
        for (int i = 0; i < 20; i++) begin
            pixel_valid = (i % 2 == 0);
            pixel_data  = 8'h88;
            pixel_last  = (i == 18);
            if (i % 2 == 0 && i <= 18) model_add(8'h88);
            @(negedge clk);
        end
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
        check("t5.bin_34", 32'(bin_34), 32'd10);
        check_all("t5");
        for (int i = 0; i < 3; i++) begin
            check("t5.ready_frozen", 32'(pixel_ready), 32'd0);
            check("t5.no_start", 32'(start_classification), 32'd0);
            @(negedge clk);
        end
        finish_frame(2'b10, "t5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/histogram_builder.md
HISTOGRAM_BUILDER -- requirements
Module: histogram_builder

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel sample width.
REQ-002 SHALL have parameter NUM_BINS, default 64, histogram bin count (power of two, >= 40).
REQ-003 SHALL have parameter BIN_W, default 12, bin counter width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pixel_valid  input  1  pixel sample present.
REQ-007 pixel_data  input  PIX_W  pixel intensity.
REQ-008 pixel_last  input  1  qualifies the final pixel of a frame.
REQ-009 pixel_ready  output  1  block accepts a pixel this cycle.
REQ-010 start_classification  output  1  one-cycle request to the classifier.
REQ-011 bin_0, bin_34, bin_38, bin_39  output  BIN_W each  bin counts presented to the classifier.
REQ-012 classification_done  input  1  classifier done level.
REQ-013 classification  input  2  classifier result.
REQ-014 result  output  2  latched class of the last completed frame.
REQ-015 result_valid  output  1  one-cycle pulse when result updates.
REQ-016 pixel_count  output  20  pixels accepted in the current or last frame, saturating at 2^20-1.

Function
REQ-017 SHALL implement FSM states CLEAR, ACCUM, HANDOFF and WAIT_DONE.
REQ-018 CLEAR SHALL zero all bins and pixel_count in one cycle, then go to ACCUM.
REQ-019 pixel_ready SHALL be 1 only in ACCUM.
REQ-020 A pixel SHALL be accepted when pixel_valid and pixel_ready are both 1.
REQ-021 Bin index SHALL be pixel_data[PIX_W-1 -: log2(NUM_BINS)], i.e. pixel_data >> 2 for the defaults.
REQ-022 The indexed bin SHALL increment by 1 at the accept edge and saturate at 2^BIN_W-1 (4095).
REQ-023 pixel_count SHALL increment on each accept, saturating.
REQ-024 An accepted pixel with pixel_last=1 SHALL be counted, then the FSM SHALL go to HANDOFF.
REQ-025 pixel_last with pixel_valid=0 SHALL be ignored.
REQ-026 HANDOFF SHALL assert start_classification for exactly one cycle, then go to WAIT_DONE.
REQ-027 Bins SHALL be frozen from HANDOFF until WAIT_DONE exits.
REQ-028 WAIT_DONE SHALL complete only on a rising edge of classification_done, meaning 1 now and 0 in the previous registered sample; a stale high level from the previous frame SHALL NOT complete it.
REQ-029 On completion, result SHALL be loaded from classification, result_valid SHALL pulse for one cycle, and the FSM SHALL go to CLEAR.
REQ-030 The done-edge detector sample register SHALL update every cycle in all states.
REQ-031 Frame latency SHALL be: last accept edge N, start_classification high in cycle N+1, earliest result_valid at N+3 with a 2-cycle classifier.
REQ-032 The bin_* outputs SHALL be direct register reads with no extra latency.

Reset
REQ-033 rst SHALL force state to CLEAR, all bins to 0, pixel_count to 0, result to 2'b00, result_valid, start_classification and the done sample to 0, and pixel_ready to 0.
REQ-034 rst asserted mid-frame or in WAIT_DONE SHALL discard the frame; no result_valid SHALL follow.
REQ-035 After rst deasserts, pixel_ready SHALL first rise one cycle later, after CLEAR.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the default PIX_W, NUM_BINS and BIN_W constants, and the classifier bin indices 0, 34, 38 and 39.
REQ-037 The bin array and its saturating-increment logic SHALL be one sub-module, hist_bin_array, with clear, inc and index inputs and a four-bin tap output.

Verification
REQ-038 Frame of 100 pixels at 0x00, then pixel_last -> bin_0=100, others 0, start pulse 1 cycle.
REQ-039 Pixels 0x88 x20, 0x98 x5, 0x9C x3, last -> bin_34=20, bin_38=5, bin_39=3.
REQ-040 5000 pixels at 0x00 -> bin_0 saturates at 4095, pixel_count=5000.
REQ-041 Classifier model holds done high from the previous frame -> no completion until done goes 0 then 1; result equals classification sampled at the rising edge, result_valid high 1 cycle.
REQ-042 rst after 50 pixels -> all outputs zero; the next frame of 10 pixels at 0x9C gives bin_39=10.
REQ-043 pixel_valid toggling every cycle, with pixel_valid low while the frame is frozen -> only valid&&ready pixels counted; pixel_ready low throughout HANDOFF and WAIT_DONE.
